// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with one-shot / auto-reload modes.
// CTRL = {IM, Mode[1:0], Enable}; irq = latched terminal-count flag gated by IM.
//   state | meaning
//   IDLE  | COUNT holds; waits for Enable
//   LOAD  | COUNT <= PRESET
//   CNT   | counting down toward terminal count
//   INT   | terminal count reached; reload (Mode 1) or stop (other modes)
module timer_counter #(
  parameter int CTRL_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t                 state;
  logic [CTRL_BITS-1:0]   ctrl;
  logic [31:0]            preset;
  logic [31:0]            count;
  logic                   irq_flag;

  logic enable;
  logic auto_reload;

  assign enable      = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign irq         = irq_flag & ctrl[3];

  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0:    dout = {{(32-CTRL_BITS){1'b0}}, ctrl};
      2'd1:    dout = preset;
      2'd2:    dout = count;
      default: dout = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= 32'd0;
            state    <= INT;
            irq_flag <= 1'b1;
          end
        end
        INT: begin
          if (auto_reload) begin
            irq_flag <= 1'b0;
            state    <= LOAD;
          end else begin
            ctrl[0] <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // CPU writes are applied last so they override same-edge FSM updates.
      if (we) begin
        case (addr)
          2'd0: begin
            ctrl     <= din[CTRL_BITS-1:0];
            irq_flag <= 1'b0;
          end
          2'd1: begin
            preset   <= din;
            irq_flag <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
